// File: rtl/i2c_sda_engine_if.sv
// Bus bundle between the SHT40 I2C master control and the SDA engine.
// The engine side is the slave modport; the controller/bench side is master.
interface i2c_sda_engine_if;
  logic       Scl_In;
  logic       Sda_In;
  logic [2:0] Master_State_Out;
  logic [7:0] Tx_Data;
  logic       Tx_Load;
  logic       Rx_Last;
  logic       Sda_Out;
  logic [7:0] Rx_Byte;
  logic       Rx_Valid;
  logic       Ack_Received;
  logic       Nack_Error;
  logic       Tx_Underrun;
  logic       Busy;

  modport master (
    output Scl_In, Sda_In, Master_State_Out,
    output Tx_Data, Tx_Load, Rx_Last,
    input  Sda_Out, Rx_Byte, Rx_Valid,
    input  Ack_Received, Nack_Error,
    input  Tx_Underrun, Busy
  );

  modport slave (
    input  Scl_In, Sda_In, Master_State_Out,
    input  Tx_Data, Tx_Load, Rx_Last,
    output Sda_Out, Rx_Byte, Rx_Valid,
    output Ack_Received, Nack_Error,
    output Tx_Underrun, Busy
  );
endinterface

// File: rtl/i2c_sda_engine.sv
// SDA-side data engine for the SHT40 I2C master: START/STOP generation,
// MSB-first byte shifting, slave ACK sampling and master ACK/NACK drive.
module i2c_sda_engine #(
  parameter int HOLD_CYCLES = 240
) (
  input logic      clk,
  input logic      rst,
  i2c_sda_engine_if.slave bus
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);

  localparam logic [2:0] M_START = 3'b001;
  localparam logic [2:0] M_TADDR = 3'b010;
  localparam logic [2:0] M_RECV  = 3'b011;
  localparam logic [2:0] M_WRITE = 3'b100;
  localparam logic [2:0] M_END   = 3'b110;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_TX     = 3'd2;
  localparam logic [2:0] S_ACK_RX = 3'd3;
  localparam logic [2:0] S_RX     = 3'd4;
  localparam logic [2:0] S_ACK_TX = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;
  localparam logic [2:0] S_RSTART = 3'd7;

  logic [2:0]    state_q, state_d;
  logic          scl_prev_q;
  logic          hold_act_q, hold_act_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    tx_hold_q, tx_hold_d;
  logic          tx_pend_q, tx_pend_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          last_q, last_d;
  logic          low_done_q, low_done_d;
  logic          sda_q, sda_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          undr_q, undr_d;
  logic          busy_q, busy_d;
  logic          fall, rise, hold_pt, load;

  assign fall    = scl_prev_q & ~bus.Scl_In;
  assign rise    = ~scl_prev_q & bus.Scl_In;
  assign hold_pt = hold_act_q && (hold_cnt_q == HOLD);

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    tx_sh_d    = tx_sh_q;
    tx_hold_d  = tx_hold_q;
    tx_pend_d  = tx_pend_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    low_done_d = low_done_q;
    sda_d      = sda_q;
    rx_byte_d  = rx_byte_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    nack_d     = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Master_State_Out == M_START && bus.Scl_In) begin
          sda_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (fall) begin
          load     = 1'b1;
          bitcnt_d = 4'd0;
          state_d  = tx_pend_q ? S_TX : S_STOP;
        end
      end
      S_TX: begin
        if (rise) bitcnt_d = bitcnt_q + 4'd1;
        if (hold_pt) begin
          if (bitcnt_q == 4'd8) begin
            sda_d    = 1'b1;
            bitcnt_d = 4'd0;
            state_d  = S_ACK_RX;
          end else begin
            sda_d = tx_sh_q[~bitcnt_q[2:0]];
          end
        end
      end
      S_ACK_RX: begin
        if (rise) begin
          ack_d  = ~bus.Sda_In;
          nack_d = bus.Sda_In;
        end
        if (fall) begin
          bitcnt_d = 4'd0;
          if (!ack_q) begin
            state_d = S_STOP;
          end else begin
            case (bus.Master_State_Out)
              M_RECV:  state_d = S_RX;
              M_START: state_d = S_RSTART;
              M_WRITE, M_TADDR: begin
                load    = 1'b1;
                state_d = tx_pend_q ? S_TX : S_STOP;
              end
              default: state_d = S_STOP;
            endcase
          end
        end
      end
      S_RX: begin
        if (hold_pt) sda_d = 1'b1;
        if (rise && bitcnt_q != 4'd8) begin
          rx_sh_d  = {rx_sh_q[6:0], bus.Sda_In};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            rx_byte_d  = {rx_sh_q[6:0], bus.Sda_In};
            rx_valid_d = 1'b1;
          end
        end
        if (fall && bitcnt_q == 4'd8) begin
          bitcnt_d = 4'd0;
          state_d  = S_ACK_TX;
        end
      end
      S_ACK_TX: begin
        if (hold_pt) begin
          sda_d  = bus.Rx_Last;
          last_d = bus.Rx_Last;
        end
        if (fall) begin
          state_d = (last_q || bus.Master_State_Out == M_END)
                  ? S_STOP : S_RX;
        end
      end
      S_STOP: begin
        // Pull low in the low phase, release only after SCL settles high.
        if (hold_pt) begin
          sda_d      = 1'b0;
          low_done_d = 1'b1;
        end else if (low_done_q && bus.Scl_In && hi_cnt_q >= HOLD_M1) begin
          sda_d      = 1'b1;
          busy_d     = 1'b0;
          low_done_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_RSTART: begin
        if (hold_pt) begin
          sda_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    undr_d = load && !tx_pend_q;
    if (load) begin
      tx_sh_d   = tx_hold_q;
      tx_pend_d = 1'b0;
    end
    if (bus.Tx_Load) begin
      tx_hold_d = bus.Tx_Data;
      tx_pend_d = 1'b1;
    end
  end

  always_comb begin
    hold_act_d = hold_act_q;
    hold_cnt_d = hold_cnt_q;
    if (fall) begin
      hold_act_d = 1'b1;
      hold_cnt_d = '0;
    end else if (hold_act_q) begin
      if (hold_cnt_q == HOLD) hold_act_d = 1'b0;
      else hold_cnt_d = hold_cnt_q + CW'(1);
    end
    hi_cnt_d = '0;
    if (bus.Scl_In)
      hi_cnt_d = (hi_cnt_q == HOLD) ? HOLD : hi_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_prev_q <= 1'b1;
      hold_act_q <= 1'b0;
      hold_cnt_q <= '0;
      hi_cnt_q   <= '0;
      bitcnt_q   <= 4'd0;
      tx_sh_q    <= 8'h00;
      tx_hold_q  <= 8'h00;
      tx_pend_q  <= 1'b0;
      rx_sh_q    <= 8'h00;
      last_q     <= 1'b0;
      low_done_q <= 1'b0;
      sda_q      <= 1'b1;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      undr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_prev_q <= bus.Scl_In;
      hold_act_q <= hold_act_d;
      hold_cnt_q <= hold_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      bitcnt_q   <= bitcnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_hold_q  <= tx_hold_d;
      tx_pend_q  <= tx_pend_d;
      rx_sh_q    <= rx_sh_d;
      last_q     <= last_d;
      low_done_q <= low_done_d;
      sda_q      <= sda_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      undr_q     <= undr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.Sda_Out      = sda_q;
  assign bus.Rx_Byte      = rx_byte_q;
  assign bus.Rx_Valid     = rx_valid_q;
  assign bus.Ack_Received = ack_q;
  assign bus.Nack_Error   = nack_q;
  assign bus.Tx_Underrun  = undr_q;
  assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_i2c_sda_engine.sv
// Directed bench for i2c_sda_engine: bench drives SCL and the slave side
// of an open-drain SDA line, with a short hold count for fast runs.
module tb_i2c_sda_engine;
  localparam logic [2:0] M_PROC  = 3'b000;
  localparam logic [2:0] M_START = 3'b001;
  localparam logic [2:0] M_TADDR = 3'b010;
  localparam logic [2:0] M_RECV  = 3'b011;
  localparam logic [2:0] M_WRITE = 3'b100;
  localparam logic [2:0] M_END   = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_sda = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   rxv_n = 0;
  int   nack_n = 0;
  int   undr_n = 0;

  i2c_sda_engine_if bif();

  i2c_sda_engine #(.HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  assign bif.Sda_In = bif.Sda_Out & slave_sda;

  always @(posedge clk) begin
    if (bif.Rx_Valid)    rxv_n  <= rxv_n + 1;
    if (bif.Nack_Error)  nack_n <= nack_n + 1;
    if (bif.Tx_Underrun) undr_n <= undr_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bitc(input logic sbit, input logic ld,
                      input logic [7:0] d, output logic seen);
    bif.Scl_In  = 1'b0;
    slave_sda   = sbit;
    bif.Tx_Load = ld;
    bif.Tx_Data = d;
    tick(1);
    bif.Tx_Load = 1'b0;
    tick(9);
    bif.Scl_In = 1'b1;
    tick(1);
    seen = bif.Sda_Out;
    tick(9);
  endtask

  task automatic tx_byte(input logic ld, input logic [7:0] d,
                         input logic ackb, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitc(1'b1, ld && i == 7, d, s);
      got[i] = s;
    end
    bitc(ackb, 1'b0, 8'h00, s);
  endtask

  task automatic rx_byte(input logic [7:0] v, output logic ack_seen);
    logic s;
    for (int i = 7; i >= 0; i--) bitc(v[i], 1'b0, 8'h00, s);
    bitc(1'b1, 1'b0, 8'h00, ack_seen);
  endtask

  task automatic load(input logic [7:0] d);
    bif.Tx_Data = d;
    bif.Tx_Load = 1'b1;
    tick(1);
    bif.Tx_Load = 1'b0;
  endtask

  task automatic gen_start(input string tag);
    slave_sda = 1'b1;
    bif.Master_State_Out = M_START;
    tick(3);
    chk({tag, "_start_sda"}, 8'(bif.Sda_Out), 8'h0);
    chk({tag, "_start_busy"}, 8'(bif.Busy), 8'h1);
    bif.Master_State_Out = M_TADDR;
  endtask

  task automatic stop_seq(input string tag);
    slave_sda = 1'b1;
    bif.Scl_In = 1'b0;
    tick(10);
    chk({tag, "_stop_low"}, 8'(bif.Sda_Out), 8'h0);
    bif.Scl_In = 1'b1;
    tick(2);
    chk({tag, "_stop_hold"}, 8'(bif.Sda_Out), 8'h0);
    tick(8);
    chk({tag, "_stop_rel"}, 8'(bif.Sda_Out), 8'h1);
    chk({tag, "_stop_busy"}, 8'(bif.Busy), 8'h0);
  endtask

  initial begin
    logic [7:0] got;
    logic       a;
    int         n0;
    bif.Scl_In = 1'b1;
    bif.Master_State_Out = M_PROC;
    bif.Tx_Data = 8'h00;
    bif.Tx_Load = 1'b0;
    bif.Rx_Last = 1'b0;
    tick(3);
    chk("rst_sda", 8'(bif.Sda_Out), 8'h1);
    chk("rst_busy", 8'(bif.Busy), 8'h0);
    chk("rst_rxbyte", bif.Rx_Byte, 8'h00);
    chk("rst_ack", 8'(bif.Ack_Received), 8'h0);
    chk("rst_valid", 8'(bif.Rx_Valid), 8'h0);
    rst = 1'b0;
    tick(3);

    // address write 0x88 with slave ACK
    load(8'h88);
    gen_start("t1");
    tx_byte(1'b0, 8'h00, 1'b0, got);
    chk("t1_addr_bits", got, 8'h88);
    chk("t1_ack", 8'(bif.Ack_Received), 8'h1);
    chk("t1_busy", 8'(bif.Busy), 8'h1);
    bif.Master_State_Out = M_END;
    stop_seq("t1");

    // address read 0x89, two read bytes, ACK then NACK
    load(8'h89);
    gen_start("t2");
    tx_byte(1'b0, 8'h00, 1'b0, got);
    chk("t2_addr_bits", got, 8'h89);
    bif.Master_State_Out = M_RECV;
    bif.Rx_Last = 1'b0;
    n0 = rxv_n;
    rx_byte(8'h66, a);
    chk("t2_rx0", bif.Rx_Byte, 8'h66);
    chk("t2_rx0_valid", 8'(rxv_n - n0), 8'd1);
    chk("t2_mack", 8'(a), 8'h0);
    bif.Rx_Last = 1'b1;
    rx_byte(8'h3A, a);
    chk("t2_rx1", bif.Rx_Byte, 8'h3A);
    chk("t2_rx1_valid", 8'(rxv_n - n0), 8'd2);
    chk("t2_mnack", 8'(a), 8'h1);
    bif.Master_State_Out = M_END;
    stop_seq("t2");
    bif.Rx_Last = 1'b0;

    // slave NACK on address
    load(8'h88);
    gen_start("t3");
    n0 = nack_n;
    tx_byte(1'b0, 8'h00, 1'b1, got);
    chk("t3_ack", 8'(bif.Ack_Received), 8'h0);
    chk("t3_nack_pulse", 8'(nack_n - n0), 8'd1);
    bif.Master_State_Out = M_WRITE;
    stop_seq("t3");

    // write with no byte loaded after address
    load(8'h88);
    gen_start("t4");
    tx_byte(1'b0, 8'h00, 1'b0, got);
    chk("t4_addr_bits", got, 8'h88);
    n0 = undr_n;
    bif.Master_State_Out = M_WRITE;
    stop_seq("t4");
    chk("t4_underrun", 8'(undr_n - n0), 8'd1);

    // Tx_Load coincident with the shift-register load
    load(8'h88);
    gen_start("t5");
    n0 = undr_n;
    tx_byte(1'b1, 8'hFD, 1'b0, got);
    chk("t5_first", got, 8'h88);
    bif.Master_State_Out = M_WRITE;
    tx_byte(1'b0, 8'h00, 1'b0, got);
    chk("t5_second", got, 8'hFD);
    chk("t5_no_underrun", 8'(undr_n - n0), 8'd0);
    bif.Master_State_Out = M_END;
    stop_seq("t5");

    // async reset while SDA is driven low mid-byte
    load(8'h88);
    gen_start("t6");
    bitc(1'b1, 1'b0, 8'h00, a);
    chk("t6_bit7", 8'(a), 8'h1);
    bif.Scl_In = 1'b0;
    tick(10);
    bif.Scl_In = 1'b1;
    tick(2);
    chk("t6_pre_sda", 8'(bif.Sda_Out), 8'h0);
    rst = 1'b1;
    #1;
    chk("t6_sda", 8'(bif.Sda_Out), 8'h1);
    chk("t6_busy", 8'(bif.Busy), 8'h0);
    chk("t6_rxbyte", bif.Rx_Byte, 8'h00);
    chk("t6_ack", 8'(bif.Ack_Received), 8'h0);
    chk("t6_valid", 8'(bif.Rx_Valid), 8'h0);
    chk("t6_nack", 8'(bif.Nack_Error), 8'h0);
    chk("t6_undr", 8'(bif.Tx_Underrun), 8'h0);
    tick(2);
    rst = 1'b0;
    bif.Master_State_Out = M_PROC;
    tick(3);
    chk("t6_post_sda", 8'(bif.Sda_Out), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
